// File: rtl/wcu_pkg.sv
// Shared definitions for the wave control unit: channel FSM encoding and
// the trigger/codeword width shared with the FIFO and timing control units.
package wcu_pkg;

  localparam int WCU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2,
    GAP  = 2'd3
  } cw_state_t;

endpackage

// File: rtl/cw_channel.sv
// One codeword output channel: accepts a trigger word, optionally waits for
// its peer, then holds the codeword for HOLD_CYCLES and idles for GAP_CYCLES.
module cw_channel
  import wcu_pkg::*;
#(
  parameter int WIDTH       = WCU_WIDTH,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             align,
  input  logic             peer_armed,
  input  logic             trg_valid,
  input  logic [WIDTH-1:0] trg_word,
  output logic             trg_ready,
  output logic [WIDTH-1:0] cw,
  output logic             cw_strobe,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             armed,
  output cw_state_t        state
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_INIT  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cw_state_t        state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [WIDTH-1:0] cw_q, cw_d;
  logic             strobe_q, strobe_d;
  logic             enter_hold;

  // Handshake: a word transfers on the rising edge where trg_valid and
  // trg_ready are both high; trg_ready is a Moore output of state and rst.
  assign trg_ready  = (state_q == IDLE) && !rst;
  assign armed      = (state_q == ARM);
  assign state      = state_q;
  assign cw         = cw_q;
  assign cw_strobe  = strobe_q;
  assign issued_cnt = issued_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trg_valid) begin
          word_d = trg_word;
          // zero words are consumed but never emitted
          if (trg_word != '0) begin
            if (align) begin
              state_d = ARM;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_INIT;
            end
          end
        end
      end
      ARM: begin
        if (peer_armed || !align) begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_INIT;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered, so they are computed from the next state
    enter_hold = (state_d == HOLD) && (state_q != HOLD);
    cw_d       = (state_d == HOLD) ? word_d : '0;
    strobe_d   = enter_hold;
    issued_d   = (enter_hold && (issued_q != '1)) ? issued_q + CNT_ONE : issued_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
      cw_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      cw_q     <= cw_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: rtl/wave_codeword_out.sv
// Two-channel codeword output stage between the timing control units and the
// AWG; the channels pair up through armed/peer_armed when align is high.
module wave_codeword_out
  import wcu_pkg::*;
#(
  parameter int WIDTH       = WCU_WIDTH,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             align,
  input  logic             trg1_valid,
  input  logic [WIDTH-1:0] trg1_word,
  output logic             trg1_ready,
  input  logic             trg2_valid,
  input  logic [WIDTH-1:0] trg2_word,
  output logic             trg2_ready,
  output logic [WIDTH-1:0] cw1,
  output logic             cw1_strobe,
  output logic [WIDTH-1:0] cw2,
  output logic             cw2_strobe,
  output logic [CNT_W-1:0] issued1_cnt,
  output logic [CNT_W-1:0] issued2_cnt,
  output cw_state_t        state1,
  output cw_state_t        state2
);

  logic armed1, armed2;

  cw_channel #(
    .WIDTH(WIDTH), .HOLD_CYCLES(HOLD_CYCLES), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
  ) u_ch1 (
    .clk(clk), .rst(rst), .align(align), .peer_armed(armed2),
    .trg_valid(trg1_valid), .trg_word(trg1_word), .trg_ready(trg1_ready),
    .cw(cw1), .cw_strobe(cw1_strobe), .issued_cnt(issued1_cnt),
    .armed(armed1), .state(state1)
  );

  cw_channel #(
    .WIDTH(WIDTH), .HOLD_CYCLES(HOLD_CYCLES), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
  ) u_ch2 (
    .clk(clk), .rst(rst), .align(align), .peer_armed(armed1),
    .trg_valid(trg2_valid), .trg_word(trg2_word), .trg_ready(trg2_ready),
    .cw(cw2), .cw_strobe(cw2_strobe), .issued_cnt(issued2_cnt),
    .armed(armed2), .state(state2)
  );

endmodule

// File: tb/tb_wave_codeword_out.sv
// Directed bench for wave_codeword_out (CNT_W=4 so saturation is reachable).
module tb_wave_codeword_out;
  import wcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, align;
  logic       trg1_valid, trg2_valid;
  logic [7:0] trg1_word, trg2_word;
  logic       trg1_ready, trg2_ready;
  logic [7:0] cw1, cw2;
  logic       cw1_strobe, cw2_strobe;
  logic [3:0] issued1_cnt, issued2_cnt;
  cw_state_t  state1, state2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wave_codeword_out #(.WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .align(align),
    .trg1_valid(trg1_valid), .trg1_word(trg1_word), .trg1_ready(trg1_ready),
    .trg2_valid(trg2_valid), .trg2_word(trg2_word), .trg2_ready(trg2_ready),
    .cw1(cw1), .cw1_strobe(cw1_strobe), .cw2(cw2), .cw2_strobe(cw2_strobe),
    .issued1_cnt(issued1_cnt), .issued2_cnt(issued2_cnt),
    .state1(state1), .state2(state2)
  );

  // advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(state1 == IDLE && state2 == IDLE) && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (n >= 50) begin
      $display("FAIL wait_idle: states %0d/%0d still busy after %0d cycles, required IDLE", state1, state2, n);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; align = 1'b0;
    trg1_valid = 1'b0; trg1_word = '0; trg2_valid = 1'b0; trg2_word = '0;
    step(); step();
    tests++;
    if ({trg1_ready, trg2_ready} !== 2'b00) begin
      $display("FAIL reset_ready: got %b, required 00", {trg1_ready, trg2_ready}); fails++;
    end
    tests++;
    if ({cw1, cw1_strobe, cw2, cw2_strobe, issued1_cnt, issued2_cnt} !== 26'd0) begin
      $display("FAIL reset_outputs: cw1=%h s1=%b cw2=%h s2=%b i1=%h i2=%h, required all 0",
               cw1, cw1_strobe, cw2, cw2_strobe, issued1_cnt, issued2_cnt); fails++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({trg1_ready, trg2_ready} !== 2'b11) begin
      $display("FAIL reset_release_ready: got %b, required 11", {trg1_ready, trg2_ready}); fails++;
    end
  endtask

  task automatic test_single_word();
    trg1_valid = 1'b1; trg1_word = 8'h3C;
    step();
    trg1_valid = 1'b0; trg1_word = '0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({cw1, cw1_strobe} !== {8'h3C, (i == 0)}) begin
        $display("FAIL single_hold[%0d]: cw1=%h strobe=%b, required 3c %b", i, cw1, cw1_strobe, (i == 0)); fails++;
      end
      step();
    end
    tests++;
    if ({cw1, cw1_strobe, trg1_ready} !== 10'd0) begin
      $display("FAIL single_gap: cw1=%h strobe=%b ready=%b, required 00 0 0", cw1, cw1_strobe, trg1_ready); fails++;
    end
    step();
    tests++;
    if ({trg1_ready, cw1, issued1_cnt} !== {1'b1, 8'h00, 4'd1}) begin
      $display("FAIL single_done: ready=%b cw1=%h issued1=%0d, required 1 00 1", trg1_ready, cw1, issued1_cnt); fails++;
    end
  endtask

  task automatic test_noop();
    trg2_valid = 1'b1; trg2_word = 8'h00;
    #1;
    tests++;
    if (trg2_ready !== 1'b1) begin
      $display("FAIL noop_ready_before: got %b, required 1", trg2_ready); fails++;
    end
    step();
    trg2_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({trg2_ready, cw2, cw2_strobe, issued2_cnt, state2} !== {1'b1, 8'h00, 1'b0, 4'd0, IDLE}) begin
        $display("FAIL noop[%0d]: ready=%b cw2=%h strobe=%b issued2=%0d state2=%0d, required 1 00 0 0 0",
                 i, trg2_ready, cw2, cw2_strobe, issued2_cnt, state2); fails++;
      end
      step();
    end
  endtask

  task automatic test_align();
    align = 1'b1;
    trg1_valid = 1'b1; trg1_word = 8'h11;
    step();
    trg1_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        trg2_valid = 1'b1; trg2_word = 8'h22;
      end
      tests++;
      if ({state1, cw1, cw1_strobe} !== {ARM, 8'h00, 1'b0}) begin
        $display("FAIL align_wait[%0d]: state1=%0d cw1=%h strobe=%b, required ARM 00 0", i, state1, cw1, cw1_strobe); fails++;
      end
      step();
    end
    trg2_valid = 1'b0;
    tests++;
    if ({state2, cw2_strobe, cw1_strobe} !== {ARM, 2'b00}) begin
      $display("FAIL align_pair_arm: state2=%0d s1=%b s2=%b, required ARM 0 0", state2, cw1_strobe, cw2_strobe); fails++;
    end
    step();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({cw1, cw2, cw1_strobe, cw2_strobe} !== {8'h11, 8'h22, (i == 0), (i == 0)}) begin
        $display("FAIL align_hold[%0d]: cw1=%h cw2=%h s1=%b s2=%b, required 11 22 %b %b",
                 i, cw1, cw2, cw1_strobe, cw2_strobe, (i == 0), (i == 0)); fails++;
      end
      step();
    end
    align = 1'b0;
    wait_idle();
  endtask

  task automatic test_align_drop();
    align = 1'b1;
    trg1_valid = 1'b1; trg1_word = 8'h55;
    step();
    trg1_valid = 1'b0;
    step();
    tests++;
    if ({state1, cw1} !== {ARM, 8'h00}) begin
      $display("FAIL drop_armed: state1=%0d cw1=%h, required ARM 00", state1, cw1); fails++;
    end
    align = 1'b0;
    step();
    tests++;
    if ({cw1, cw1_strobe, cw2, cw2_strobe, state2} !== {8'h55, 1'b1, 8'h00, 1'b0, IDLE}) begin
      $display("FAIL drop_release: cw1=%h s1=%b cw2=%h s2=%b state2=%0d, required 55 1 00 0 IDLE",
               cw1, cw1_strobe, cw2, cw2_strobe, state2); fails++;
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_hold();
    trg1_valid = 1'b1; trg1_word = 8'hA5;
    step();
    trg1_valid = 1'b0;
    step();
    tests++;
    if ({cw1, cw1_strobe} !== {8'hA5, 1'b0}) begin
      $display("FAIL midhold_second: cw1=%h strobe=%b, required a5 0", cw1, cw1_strobe); fails++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (trg1_ready !== 1'b0) begin
      $display("FAIL midhold_ready_in_rst: got %b, required 0", trg1_ready); fails++;
    end
    step();
    tests++;
    if ({cw1, cw1_strobe, issued1_cnt, state1} !== {8'h00, 1'b0, 4'd0, IDLE}) begin
      $display("FAIL midhold_cleared: cw1=%h strobe=%b issued1=%0d state1=%0d, required 00 0 0 IDLE",
               cw1, cw1_strobe, issued1_cnt, state1); fails++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (trg1_ready !== 1'b1) begin
      $display("FAIL midhold_ready_after: got %b, required 1", trg1_ready); fails++;
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int last_cyc = 0;
    logic acc;
    logic [7:0] word;
    logic [3:0] exp_cnt;
    word = 8'h01;
    trg1_valid = 1'b1; trg1_word = word;
    for (int cyc = 0; cyc < 20 * 6; cyc++) begin
      acc = trg1_ready;
      step();
      if (acc) begin
        accepts++;
        exp_cnt = (accepts >= 15) ? 4'hF : 4'(accepts);
        if (accepts > 1) begin
          tests++;
          if (cyc - last_cyc != 6) begin
            $display("FAIL b2b_interval[%0d]: got %0d cycles, required 6", accepts, cyc - last_cyc); fails++;
          end
        end
        last_cyc = cyc;
        tests++;
        if ({cw1, cw1_strobe, issued1_cnt} !== {word, 1'b1, exp_cnt}) begin
          $display("FAIL b2b_issue[%0d]: cw1=%h strobe=%b issued1=%h, required %h 1 %h",
                   accepts, cw1, cw1_strobe, issued1_cnt, word, exp_cnt); fails++;
        end
        word = word + 8'd1;
        trg1_word = word;
      end
    end
    trg1_valid = 1'b0;
    tests++;
    if ({accepts >= 17, issued1_cnt} !== {1'b1, 4'hF}) begin
      $display("FAIL b2b_saturate: accepts=%0d issued1=%h, required >=17 f", accepts, issued1_cnt); fails++;
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_noop();
    test_align();
    test_align_drop();
    test_reset_mid_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
